// File: rtl/boreal_vns_pkg.sv
// Shared types and field widths for the VNS biphasic pulse-train controller.
// Optional soft-start ramp is selected with BOREAL_VNS_RAMP_EN (see top).
package boreal_vns_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CATH    = 3'd1,
      GAP     = 3'd2,
      ANOD    = 3'd3,
      REST    = 3'd4,
      LOCKOUT = 3'd5
   } state_t;

   localparam int AMP_W_DEF      = 12;
   localparam int PHASE_W        = 16;
   localparam int GAP_W          = 8;
   localparam int PERIOD_W       = 16;
   localparam int COUNT_W        = 8;
   localparam int REST_W         = 18;
   localparam int LOCKOUT_US_DEF = 2_000_000;
   // Microsecond counter must cover both the longest phase and the lockout quiet time.
   localparam int US_CNT_W       = 24;

endpackage

// File: rtl/boreal_us_tick.sv
// Microsecond prescaler: tick is high on the last clock of each TICK_DIV-clock
// interval; restart realigns the interval to the following clock.
module boreal_us_tick #(
   parameter int TICK_DIV = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_reg;

   assign tick = (cnt_reg == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (restart || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/boreal_vns_stim_ctrl.sv
// VNS pulse-train controller: req/ack intake, charge-balanced biphasic trains,
// AD-guard lockout. Define BOREAL_VNS_RAMP_EN for soft-start amplitude.
module boreal_vns_stim_ctrl
   import boreal_vns_pkg::*;
#(
   parameter int TICK_DIV   = 100,
   parameter int AMP_W      = AMP_W_DEF,
   parameter int LOCKOUT_US = LOCKOUT_US_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stim_req,
   output logic                stim_ack,
   input  logic [AMP_W-1:0]    amp_code,
   input  logic [PHASE_W-1:0]  phase_us,
   input  logic [GAP_W-1:0]    interphase_us,
   input  logic [PERIOD_W-1:0] period_us,
   input  logic [COUNT_W-1:0]  n_pulses,
   input  logic                ad_guard_active,
   output logic                dac_en,
   output logic                dac_polarity,
   output logic [AMP_W-1:0]    dac_code,
   output logic                stim_busy,
   output logic                lockout,
   output logic                abort_pulse
);

   state_t               state_reg, state_next;
   logic [AMP_W-1:0]     amp_reg, amp_next;
   logic [PHASE_W-1:0]   phase_reg;
   logic [PHASE_W-1:0]   anod_reg, anod_next;
   logic [GAP_W-1:0]     gap_reg;
   logic [REST_W-1:0]    rest_reg, rest_calc, active_us;
   logic [COUNT_W-1:0]   npulse_reg;
   logic [COUNT_W-1:0]   pcnt_reg, pcnt_next;
   logic [US_CNT_W-1:0]  us_cnt_reg, us_elapsed;
   logic                 guard_seen_reg, guard_seen_next;
   logic                 accept, abort_next, params_ok, in_train;
   logic                 tick, restart, dac_on;
   logic                 cath_done, gap_done, anod_done, rest_done, quiet_done;
   logic [AMP_W-1:0]     code_next;

`ifdef BOREAL_VNS_RAMP_EN
   function automatic logic [AMP_W-1:0] ramp_code(input logic [AMP_W-1:0] amp,
                                                  input logic [COUNT_W-1:0] k);
      case (k)
         COUNT_W'(0): ramp_code = amp >> 2;
         COUNT_W'(1): ramp_code = amp >> 1;
         COUNT_W'(2): ramp_code = amp - (amp >> 2);
         default:     ramp_code = amp;
      endcase
   endfunction
`endif

   // Quiet time is measured from the last guard-high clock, so the guard also realigns the prescaler.
   assign restart = (state_next != state_reg) || ((state_reg == LOCKOUT) && ad_guard_active);

   boreal_us_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .tick    (tick)
   );

   assign us_elapsed = us_cnt_reg + 1'b1;
   assign cath_done  = tick && (us_elapsed == US_CNT_W'(phase_reg));
   assign gap_done   = tick && (us_elapsed == US_CNT_W'(gap_reg));
   assign anod_done  = tick && (us_elapsed == US_CNT_W'(anod_reg));
   assign rest_done  = tick && (us_elapsed == US_CNT_W'(rest_reg));
   assign quiet_done = tick && (us_elapsed == US_CNT_W'(LOCKOUT_US));

   assign params_ok = (n_pulses != '0) && (phase_us != '0) && (amp_code != '0);
   assign active_us = {1'b0, phase_us, 1'b0} + REST_W'(interphase_us);
   assign rest_calc = ({2'b00, period_us} > active_us) ? ({2'b00, period_us} - active_us) : '0;
   assign in_train  = (state_reg == CATH) || (state_reg == GAP) ||
                      (state_reg == ANOD) || (state_reg == REST);

   always_comb begin
      state_next      = state_reg;
      accept          = 1'b0;
      abort_next      = 1'b0;
      guard_seen_next = guard_seen_reg;
      pcnt_next       = pcnt_reg;
      anod_next       = anod_reg;

      if (in_train && ad_guard_active) begin
         guard_seen_next = 1'b1;
         abort_next      = !guard_seen_reg;
      end

      case (state_reg)
         IDLE: begin
            if (ad_guard_active) begin
               state_next = LOCKOUT;
            end else if (stim_req) begin
               accept    = 1'b1;
               pcnt_next = '0;
               anod_next = phase_us;
               if (params_ok) state_next = CATH;
            end
         end
         CATH: begin
            // A cut-short cathodic phase is mirrored by an equally short anodic one.
            if (ad_guard_active || cath_done) begin
               if (ad_guard_active) anod_next = PHASE_W'(us_elapsed);
               state_next = (gap_reg == '0) ? ANOD : GAP;
            end
         end
         GAP: begin
            if (gap_done) state_next = ANOD;
         end
         ANOD: begin
            if (anod_done) begin
               pcnt_next = pcnt_reg + 1'b1;
               if (guard_seen_reg || ad_guard_active) state_next = LOCKOUT;
               else if (pcnt_next == npulse_reg)      state_next = IDLE;
               else if (rest_reg == '0)               state_next = CATH;
               else                                   state_next = REST;
            end
         end
         REST: begin
            if (ad_guard_active)  state_next = LOCKOUT;
            else if (rest_done)   state_next = CATH;
         end
         LOCKOUT: begin
            if (!ad_guard_active && quiet_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if ((state_next == IDLE) || (state_next == LOCKOUT)) guard_seen_next = 1'b0;
   end

   assign amp_next = accept ? amp_code : amp_reg;
   assign dac_on   = (state_next == CATH) || (state_next == ANOD);
`ifdef BOREAL_VNS_RAMP_EN
   assign code_next = dac_on ? ramp_code(amp_next, pcnt_next) : '0;
`else
   assign code_next = dac_on ? amp_next : '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         amp_reg        <= '0;
         phase_reg      <= '0;
         anod_reg       <= '0;
         gap_reg        <= '0;
         rest_reg       <= '0;
         npulse_reg     <= '0;
         pcnt_reg       <= '0;
         us_cnt_reg     <= '0;
         guard_seen_reg <= 1'b0;
         stim_ack       <= 1'b0;
         dac_en         <= 1'b0;
         dac_polarity   <= 1'b0;
         dac_code       <= '0;
         stim_busy      <= 1'b0;
         lockout        <= 1'b0;
         abort_pulse    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         amp_reg        <= amp_next;
         anod_reg       <= anod_next;
         pcnt_reg       <= pcnt_next;
         guard_seen_reg <= guard_seen_next;
         if (accept) begin
            phase_reg  <= phase_us;
            gap_reg    <= interphase_us;
            rest_reg   <= rest_calc;
            npulse_reg <= n_pulses;
         end
         if (restart)   us_cnt_reg <= '0;
         else if (tick) us_cnt_reg <= us_cnt_reg + 1'b1;
         stim_ack     <= accept;
         abort_pulse  <= abort_next;
         dac_en       <= dac_on;
         dac_polarity <= (state_next == ANOD);
         dac_code     <= code_next;
         stim_busy    <= (state_next == CATH) || (state_next == GAP) ||
                         (state_next == ANOD) || (state_next == REST);
         lockout      <= (state_next == LOCKOUT);
      end
   end

endmodule

// File: tb/tb_boreal_vns_stim_ctrl.sv
// Scoreboard bench: expected output segments (state tuple + length in clocks)
// are queued with each stimulus and compared as the DUT output changes.
module tb_boreal_vns_stim_ctrl;

   localparam int TD  = 4;
   localparam int LUS = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stim_req;
   logic        stim_ack;
   logic [11:0] amp_code;
   logic [15:0] phase_us;
   logic [7:0]  interphase_us;
   logic [15:0] period_us;
   logic [7:0]  n_pulses;
   logic        ad_guard_active;
   logic        dac_en, dac_polarity, stim_busy, lockout, abort_pulse;
   logic [11:0] dac_code;

   boreal_vns_stim_ctrl #(.TICK_DIV(TD), .AMP_W(12), .LOCKOUT_US(LUS)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stim_req        (stim_req),
      .stim_ack        (stim_ack),
      .amp_code        (amp_code),
      .phase_us        (phase_us),
      .interphase_us   (interphase_us),
      .period_us       (period_us),
      .n_pulses        (n_pulses),
      .ad_guard_active (ad_guard_active),
      .dac_en          (dac_en),
      .dac_polarity    (dac_polarity),
      .dac_code        (dac_code),
      .stim_busy       (stim_busy),
      .lockout         (lockout),
      .abort_pulse     (abort_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] t;
      int          len;
   } seg_t;

   seg_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc = 0, run_len = 0, ack_cnt = 0, abort_cnt = 0, en_cnt = 0;
   int          lock_last = 0, ack_gap = 0;
   logic [15:0] cur_t = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] tup(input logic en, input logic pol, input logic [11:0] code,
                                       input logic busy, input logic lk);
      return {en, pol, code, busy, lk};
   endfunction

   function automatic logic [11:0] exp_code(input logic [11:0] amp, input int k);
`ifdef BOREAL_VNS_RAMP_EN
      if (k == 0) return amp >> 2;
      if (k == 1) return amp >> 1;
      if (k == 2) return amp - (amp >> 2);
`endif
      return amp;
   endfunction

   task automatic push_seg(input logic [15:0] t, input int len);
      seg_t s;
      s.t   = t;
      s.len = len;
      sb_q.push_back(s);
   endtask

   task automatic push_train(input logic [11:0] amp, input int ph, input int gp, input int per, input int n);
      int rest;
      rest = per - 2 * ph - gp;
      if (rest < 0) rest = 0;
      for (int k = 0; k < n; k++) begin
         push_seg(tup(1, 0, exp_code(amp, k), 1, 0), ph * TD);
         if (gp > 0) push_seg(tup(0, 0, 12'h0, 1, 0), gp * TD);
         push_seg(tup(1, 1, exp_code(amp, k), 1, 0), ph * TD);
         if (k < n - 1 && rest > 0) push_seg(tup(0, 0, 12'h0, 1, 0), rest * TD);
      end
   endtask

   // Output monitor: a segment closes when the output tuple changes.
   always @(negedge clk) begin
      if (rst_n) begin
         logic [15:0] now_t;
         seg_t        s;
         cyc++;
         if (lockout) lock_last = cyc;
         if (stim_ack) begin
            ack_cnt++;
            ack_gap = cyc - lock_last;
         end
         if (abort_pulse) abort_cnt++;
         if (dac_en) en_cnt++;
         now_t = tup(dac_en, dac_polarity, dac_code, stim_busy, lockout);
         if (now_t != cur_t) begin
            if (cur_t != '0) begin
               if (sb_q.size() == 0) begin
                  check("sb_unexpected_seg", {16'h0, cur_t}, 32'h0);
               end else begin
                  s = sb_q.pop_front();
                  check("seg_state", {16'h0, cur_t}, {16'h0, s.t});
                  check("seg_len", run_len, s.len);
               end
            end
            cur_t   = now_t;
            run_len = 1;
         end else begin
            run_len++;
         end
      end
   end

   // sel: 0 polarity, 1 dac_en, 2 lockout, 3 idle, 4 ack
   task automatic wait_for(input string tag, input int sel, input logic val);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         case (sel)
            0: hit = (dac_polarity == val);
            1: hit = (dac_en == val);
            2: hit = (lockout == val);
            3: hit = ((!stim_busy && !lockout) == val);
            default: hit = (stim_ack == val);
         endcase
         if (!hit) @(negedge clk);
      end
      check(tag, hit, 1'b1);
   endtask

   task automatic req(input string tag, input logic [11:0] a, input int ph, input int gp,
                      input int per, input int n);
      amp_code      = a;
      phase_us      = 16'(ph);
      interphase_us = 8'(gp);
      period_us     = 16'(per);
      n_pulses      = 8'(n);
      stim_req      = 1'b1;
      @(negedge clk);
      wait_for(tag, 4, 1'b1);
      stim_req      = 1'b0;
      amp_code      = 12'($urandom);
      phase_us      = 16'($urandom_range(1, 3));
      interphase_us = 8'($urandom);
      period_us     = 16'($urandom);
      n_pulses      = 8'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ab0, en0;
      rst_n = 1'b0; stim_req = 1'b0; ad_guard_active = 1'b0;
      amp_code = '0; phase_us = '0; interphase_us = '0; period_us = '0; n_pulses = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {stim_ack, dac_en, dac_polarity, dac_code, stim_busy, lockout, abort_pulse}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: nominal three-pulse train; inputs scrambled after accept
      push_train(12'h400, 10, 5, 50, 3);
      req("ack_t1", 12'h400, 10, 5, 50, 3);
      wait_for("idle_t1", 3, 1'b1);
      repeat (3) @(negedge clk);

      // 2: guard 5.5 us into the first cathodic phase -> 6 us anodic, then lockout
      ab0 = abort_cnt;
      push_seg(tup(1, 0, exp_code(12'h400, 0), 1, 0), 23);
      push_seg(tup(0, 0, 12'h0, 1, 0), 5 * TD);
      push_seg(tup(1, 1, exp_code(12'h400, 0), 1, 0), 6 * TD);
      push_seg(tup(0, 0, 12'h0, 0, 1), 8 + LUS * TD);
      req("ack_t2", 12'h400, 10, 5, 50, 3);
      repeat (22) @(negedge clk);
      ad_guard_active = 1'b1;
      wait_for("lock_t2", 2, 1'b1);
      repeat (8) @(negedge clk);
      ad_guard_active = 1'b0;
      wait_for("idle_t2", 3, 1'b1);
      check("abort_once_t2", abort_cnt - ab0, 1);
      repeat (3) @(negedge clk);

      // 3: one-clock guard in REST; request held through lockout is acked only after it
      ab0 = abort_cnt;
      push_seg(tup(1, 0, exp_code(12'h800, 0), 1, 0), 2 * TD);
      push_seg(tup(0, 0, 12'h0, 1, 0), 1 * TD);
      push_seg(tup(1, 1, exp_code(12'h800, 0), 1, 0), 2 * TD);
      push_seg(tup(0, 0, 12'h0, 1, 0), 11);
      push_seg(tup(0, 0, 12'h0, 0, 1), LUS * TD);
      push_train(12'h010, 1, 0, 1, 1);
      req("ack_t3a", 12'h800, 2, 1, 20, 3);
      wait_for("anod_t3", 0, 1'b1);
      wait_for("rest_t3", 1, 1'b0);
      repeat (10) @(negedge clk);
      ad_guard_active = 1'b1;
      @(negedge clk);
      ad_guard_active = 1'b0;
      req("ack_t3b", 12'h010, 1, 0, 1, 1);
      @(posedge clk);
      check("ack_after_lockout", ack_gap, 2);
      check("abort_once_t3", abort_cnt - ab0, 1);
      @(negedge clk);
      wait_for("idle_t3", 3, 1'b1);
      repeat (3) @(negedge clk);

      // 4: guard re-asserts 15 us into the quiet time; exit 20 us after the last fall
      ab0 = abort_cnt;
      push_seg(tup(0, 0, 12'h0, 0, 1), 2 + 15 * TD + 2 + LUS * TD);
      ad_guard_active = 1'b1;
      repeat (3) @(negedge clk);
      ad_guard_active = 1'b0;
      repeat (15 * TD) @(negedge clk);
      ad_guard_active = 1'b1;
      repeat (2) @(negedge clk);
      ad_guard_active = 1'b0;
      wait_for("idle_t4", 3, 1'b1);
      check("no_abort_t4", abort_cnt - ab0, 0);
      repeat (3) @(negedge clk);

      // 5: degenerate requests are acked but never drive the DAC
      for (int i = 0; i < 3; i++) begin
         en0 = en_cnt;
         case (i)
            0:       req("ack_t5_n0", 12'h400, 10, 5, 50, 0);
            1:       req("ack_t5_ph0", 12'h400, 0, 5, 50, 2);
            default: req("ack_t5_amp0", 12'h000, 10, 5, 50, 2);
         endcase
         repeat (30) @(negedge clk);
         check("inval_no_dac", en_cnt - en0, 0);
         check("inval_not_busy", stim_busy, 1'b0);
      end

      // 6: period shorter than the pulse -> REST skipped, back-to-back pulses
      push_train(12'h400, 10, 0, 10, 4);
      req("ack_t6", 12'h400, 10, 0, 10, 4);
      wait_for("idle_t6", 3, 1'b1);
      repeat (5) @(negedge clk);

      check("ack_count", ack_cnt, 8);
      check("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
